// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption core: one full round per clock, round keys
// expanded forward on the fly from the cipher key.
module aes_enc_core #(
    parameter int K = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] key,
    input  logic [127:0] plaintext,
    output logic         ready,
    output logic         done,
    output logic [127:0] cyphertext,
    output logic [1:0]   fsm_state
);

    generate
        if (K != 128) begin : g_bad_key_len
            $error("aes_enc_core: K must be 128");
        end
    endgenerate

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Byte x of the S-box sits at SBOX[8*(255-x) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Column bytes are rows 0..3 from MSB down.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [1:0]   fsm;
    logic [127:0] blk;
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic [7:0]   rcon;

    logic [127:0] sub_st, shf, mix, round_out;
    logic [31:0]  kt, n0, n1, n2, n3;
    logic         accept;

    // Handshake: a block is taken on any rising edge where start=1 and ready=1;
    // done marks the single cycle in which a new cyphertext first appears.
    assign ready     = (fsm != RUN);
    assign done      = (fsm == DONE);
    assign accept    = start && ready;
    assign fsm_state = fsm;

    assign kt = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h000000};
    assign n0 = rk[127:96] ^ kt;
    assign n1 = rk[95:64]  ^ n0;
    assign n2 = rk[63:32]  ^ n1;
    assign n3 = rk[31:0]   ^ n2;

    always_comb begin
        sub_st = '0;
        shf    = '0;
        mix    = '0;
        for (int i = 0; i < 16; i++) begin
            sub_st[127-8*i -: 8] = sbox(blk[127-8*i -: 8]);
        end
        // Row r of column c takes the byte from column (c+r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf[127-8*(4*c+r) -: 8] = sub_st[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix[127-32*c -: 32] = mix_col(shf[127-32*c -: 32]);
        end
    end

    assign round_out = ((rnd == 4'd10) ? shf : mix) ^ {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm        <= IDLE;
            blk        <= '0;
            rk         <= '0;
            rnd        <= '0;
            rcon       <= '0;
            cyphertext <= '0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (accept) begin
                        blk  <= plaintext ^ key;
                        rk   <= key;
                        rnd  <= 4'd1;
                        rcon <= 8'h01;
                        fsm  <= RUN;
                    end else begin
                        fsm  <= IDLE;
                    end
                end
                RUN: begin
                    blk  <= round_out;
                    rk   <= {n0, n1, n2, n3};
                    rnd  <= rnd + 4'd1;
                    rcon <= xtime(rcon);
                    if (rnd == 4'd10) begin
                        cyphertext <= round_out;
                        fsm        <= DONE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_core.sv
// Bench for aes_enc_core: FIPS-197 vectors, back-to-back, input churn and
// mid-operation reset, checked by a scoreboard monitor on the done pulse.
module tb_aes_enc_core;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         ready;
    logic         done;
    logic [127:0] cyphertext;
    logic [1:0]   fsm_state;

    logic [127:0] exp_q[$];
    int           cyc_q[$];
    logic [127:0] hold_exp;
    logic         prev_done;
    int           cyc;
    int           total;
    int           bad;

    aes_enc_core #(.K(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .plaintext  (plaintext),
        .ready      (ready),
        .done       (done),
        .cyphertext (cyphertext),
        .fsm_state  (fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // monitor: pops the scoreboard on each done, otherwise checks hold
    always @(negedge clk) begin
        if (done) begin
            total++;
            if (prev_done) begin
                bad++;
                $display("FAIL done_twice: done high two cycles in a row at cycle %0d", cyc);
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cycle %0d, none expected", cyc);
            end else begin
                logic [127:0] e;
                int           c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                total++;
                if (cyphertext !== e) begin
                    bad++;
                    $display("FAIL ciphertext: got %h want %h", cyphertext, e);
                end
                total++;
                if (cyc !== c) begin
                    bad++;
                    $display("FAIL latency: done at cycle %0d want %0d", cyc, c);
                end
                hold_exp = e;
            end
        end else begin
            total++;
            if (cyphertext !== hold_exp) begin
                bad++;
                $display("FAIL hold: cyphertext %h want %h at cycle %0d", cyphertext, hold_exp, cyc);
            end
        end
        prev_done = done;
    end

    // driver tasks: all entered and left just after a rising edge
    task automatic check_bit(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    task automatic issue(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
        check_bit("ready_before_start", ready, 1'b1);
        key       = k;
        plaintext = p;
        start     = 1'b1;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 11);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        hold_exp  = '0;
        prev_done = 1'b0;
        reset     = 1'b0;
        start     = 1'b0;
        key       = '0;
        plaintext = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_ready", ready, 1'b1);
        check_bit("reset_done", done, 1'b0);
        total++;
        if (cyphertext !== 128'h0) begin
            bad++;
            $display("FAIL reset_ct: got %h want 0", cyphertext);
        end
        total++;
        if (fsm_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_fsm: got %0d want 0", fsm_state);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue(KEY_B, PT_B, CT_B);
        drain();
        issue(KEY_C, PT_C, CT_C);
        drain();

        // back-to-back: second start lands in the first done cycle
        issue(KEY_B, PT_B, CT_B);
        repeat (10) @(posedge clk);
        #1;
        check_bit("b2b_done_cycle", done, 1'b1);
        issue(KEY_C, PT_C, CT_C);
        drain();

        // churn: random inputs every cycle, ignored start during RUN
        issue(KEY_B, PT_B, CT_B);
        for (int i = 0; i < 12; i++) begin
            key       = {$urandom, $urandom, $urandom, $urandom};
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            start     = (i == 3);
            if (i == 3) check_bit("ready_in_run", ready, 1'b0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        drain();

        // reset in the middle of a run
        issue(KEY_C, PT_C, CT_C);
        repeat (5) @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        hold_exp = '0;
        #1;
        check_bit("abort_ready", ready, 1'b1);
        check_bit("abort_done", done, 1'b0);
        total++;
        if (cyphertext !== 128'h0) begin
            bad++;
            $display("FAIL abort_ct: got %h want 0", cyphertext);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        issue(KEY_C, PT_C, CT_C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_enc_core.md
# aes_enc_core

Iterative AES-128 encryption core: accepts a 128-bit key and plaintext block on a start/ready handshake and produces the ciphertext 10 cycles later. It computes one full round per clock. Round keys are expanded forward on the fly, with no key-schedule storage. It is the forward-direction companion to the team's decryption core and uses the same state byte packing. It runs directly on the system clock; there is no internal clock divider.

## Interface
- `K`, default 128: key length in bits. Only 128 is legal. Any other value must stop elaboration with `$error`.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to encrypt; accepted only when `ready`=1.
- `key`  in  K: cipher key; sampled only at the accept edge.
- `plaintext`  in  128: input block; sampled only at the accept edge.
- `ready`  out  1: core can accept `start` this cycle.
- `done`  out  1: one-cycle pulse; `cyphertext` is valid from this cycle.
- `cyphertext`  out  128: registered result; held until the next completion.

## Operation
- Byte packing, for key, state and output alike:
  - Byte [127:120] is S0,0 and [119:112] is S1,0, column-major.
  - Words: w[0]=[127:96] … w[3]=[31:0].
- FSM states:
  - IDLE: `ready`=1. On `start`=1 →
    - state ← plaintext ^ key
    - rk ← key
    - rnd ← 1
    - rcon ← 8'h01
    - go to RUN.
  - RUN: each cycle:
    - nk = expand(rk, rcon), where SubWord(RotWord(w[3]))^rcon feeds w[0] and each following word is chained XOR.
    - state ← round(state, nk); rk ← nk; rnd ← rnd+1; rcon ← xtime(rcon).
    - round = SubBytes → ShiftRows → MixColumns → AddRoundKey. MixColumns is bypassed when rnd==10.
    - When rnd==10: `cyphertext` ← round result, go to DONE.
  - DONE: `done`=1 and `ready`=1 for exactly this cycle.
    - `start`=1 here is accepted with IDLE semantics and goes to RUN (back-to-back).
    - Otherwise → IDLE.
- rcon sequence, generated by xtime (shift left, XOR 8'h1B on carry-out): 01,02,04,08,10,20,40,80,1B,36. No rcon ROM.
- S-box: 20 combinational lookups (16 SubBytes + 4 SubWord), all in one cycle.
- `start` while in RUN is ignored. There is no queueing and no error flag.
- `key`/`plaintext` may change freely after the accept edge without affecting the result.
- `cyphertext` changes only on the rnd==10 edge. It is stable through the following RUN of a back-to-back operation.

## Timing
- Reset values (async assert, sync deassert expected externally):
  - FSM=IDLE, `ready`=1, `done`=0, `cyphertext`=0.
  - rk, state, rnd and rcon are all 0.
- Accept edge E (the edge that samples `start`=1 with `ready`=1):
  - `ready`=0 from E to E+10.
  - Edges E+1..E+10 perform rounds 1..10.
  - `done`=1 in the cycle after E+10.
- Latency: 11 cycles from the cycle `start` is presented to the `done` cycle.
- Throughput: one block per 11 cycles, including back-to-back accept in the DONE cycle.
- Reset asserted mid-RUN: the operation is aborted immediately.
  - All outputs return to their reset values, including a previously valid `cyphertext`.
  - No `done` pulse is produced.
- `done` is never high for two consecutive cycles.

## Test plan
- FIPS-197 App. B:
  - Inputs: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: `cyphertext` 3925841d02dc09fbdc118597196a0b32.
  - Required: `done` exactly 11 cycles after `start` is presented.
- FIPS-197 App. C.1:
  - Inputs: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back:
  - Stimulus: start App. B, then start App. C.1 in its `done` cycle.
  - Required: second `done` 11 cycles later.
  - Required: App. B result held on `cyphertext` until that second `done`.
- Start during RUN and input churn:
  - Stimulus: pulse `start` at E+4 and randomize `key`/`plaintext` every cycle after E.
  - Required: a single `done` and the App. B ciphertext.
- Reset mid-operation:
  - Stimulus: drive `reset` low at E+5 for one cycle.
  - Required: `ready`=1, `done`=0 and `cyphertext`=0 immediately, with no later `done`.
  - Required: a fresh App. C.1 run afterwards is correct.
